// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 input front-end: block geometry and the slot record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int BLOCK_W = 512;  // SHA-256 message block width
  localparam int WORD_W  = 32;   // native SHA-256 word width
  localparam int LEVEL_W = 3;    // occupancy counter width, covers 0..4 slots

  // One buffered block together with its message-boundary tags.
  typedef struct packed {
    logic [BLOCK_W-1:0] data;
    logic               first;
    logic               last;
  } blk_t;

endpackage

// File: rtl/sha256_blk_fifo.sv
// Slot FIFO of complete message blocks, depth NBUF (any value 1..4), head shown combinationally.
// Latency: a pushed block is visible at the head from the cycle after the push edge.
// Backpressure: full is decoded from the level register; push while full and pop while empty are ignored.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_dat     write one block into the tail slot
//   pop                release the head slot
//   head_dat           head slot contents, all-zero while empty
//   level, full, empty occupancy status
module sha256_blk_fifo
  import sha256_pkg::*;
#(
  parameter int NBUF = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  blk_t               push_dat,
  input  logic               pop,
  output blk_t               head_dat,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int PW = (NBUF > 1) ? $clog2(NBUF) : 1;

  blk_t          slots [NBUF];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths stay in range.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LEVEL_W'(NBUF));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      // Simultaneous push and pop cancel out.
      level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
    end
  end

  // Slot storage needs no reset: it is only observed through the empty gate below.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_dat;
  end

  assign head_dat = empty ? '0 : slots[rd_ptr];

endmodule

// File: rtl/sha256_block_loader.sv
// Packs DATA_W-bit host words big-endian into 512-bit blocks tagged first/last and queues them for the core.
// Latency: block valid one cycle after its final word is accepted.
// Backpressure: busy while all NBUF slots are full; words offered while busy are dropped and flagged sticky.
//
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   data, write_enable                  host word and strobe (accepted when !busy)
//   first_block, last_block             message boundary tags for the accepted word
//   busy, level                         slot FIFO full flag and occupancy
//   blk_valid, blk_ready                core handshake for the head block
//   blk_data, blk_first, blk_last       head block and its tags (zero while empty)
//   overflow_err                        sticky dropped-write indicator
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NBUF   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data,
  input  logic               write_enable,
  input  logic               first_block,
  input  logic               last_block,
  output logic               busy,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow_err
);

  localparam int WPB = BLOCK_W / DATA_W;
  localparam int WCW = $clog2(WPB);

  logic [DATA_W-1:0]  words [WPB];
  logic [WCW-1:0]     wcnt;
  logic [WCW-1:0]     idx;
  logic               first_flag;
  logic               last_flag;
  logic               accept;
  logic               commit;
  logic               first_eff;
  logic               last_eff;
  logic [BLOCK_W-1:0] asm_flat;
  blk_t               push_dat;
  blk_t               head_dat;
  logic               fifo_full;
  logic               fifo_empty;

  assign accept = write_enable && !busy;

  // A first_block word always restarts the block at slot 0, abandoning any partial block.
  assign idx    = first_block ? '0 : wcnt;
  assign commit = accept && (idx == WCW'(WPB - 1));

  assign first_eff = first_block || first_flag;
  // A restart also drops a last tag that belonged to the abandoned partial block.
  assign last_eff  = last_block || (last_flag && !first_block);

  // Flattened view of the block including the word being accepted this cycle,
  // so the final word can be committed on the same edge it arrives.
  for (genvar gi = 0; gi < WPB; gi++) begin : g_pack
    assign asm_flat[BLOCK_W-1-gi*DATA_W -: DATA_W] =
        (accept && (idx == WCW'(gi))) ? data : words[gi];
  end

  always_ff @(posedge clk) begin
    if (accept) words[idx] <= data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt         <= '0;
      first_flag   <= 1'b0;
      last_flag    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (write_enable && busy) overflow_err <= 1'b1;
      if (commit) begin
        wcnt       <= '0;
        first_flag <= 1'b0;
        last_flag  <= 1'b0;
      end else if (accept) begin
        wcnt       <= idx + 1'b1;
        first_flag <= first_eff;
        last_flag  <= last_eff;
      end
    end
  end

  assign push_dat.data  = asm_flat;
  assign push_dat.first = first_eff;
  assign push_dat.last  = last_eff;

  sha256_blk_fifo #(
    .NBUF (NBUF)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (commit),
    .push_dat (push_dat),
    .pop      (blk_valid && blk_ready),
    .head_dat (head_dat),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign busy      = fifo_full;
  assign blk_valid = !fifo_empty;
  assign blk_data  = head_dat.data;
  assign blk_first = head_dat.first;
  assign blk_last  = head_dat.last;

endmodule

// File: tb/tb_sha256_block_loader.sv
// Scoreboard bench for the block loader: two instances (32-bit words / 2 slots, 8-bit words / 3 slots).
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256_block_loader;

  localparam int NB_A = 2;
  localparam int NB_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         we_a, f_a, l_a, rdy_a;
  logic [31:0]  d_a;
  logic         busy_a, vld_a, first_a, last_a, ovf_a;
  logic [511:0] bd_a;
  logic [2:0]   lvl_a;

  logic         we_b, f_b, l_b, rdy_b;
  logic [7:0]   d_b;
  logic         busy_b, vld_b, first_b, last_b, ovf_b;
  logic [511:0] bd_b;
  logic [2:0]   lvl_b;

  sha256_block_loader #(.DATA_W(32), .NBUF(NB_A)) dut_a (
    .clk(clk), .reset(reset), .data(d_a), .write_enable(we_a), .first_block(f_a),
    .last_block(l_a), .busy(busy_a), .blk_valid(vld_a), .blk_ready(rdy_a),
    .blk_data(bd_a), .blk_first(first_a), .blk_last(last_a), .level(lvl_a),
    .overflow_err(ovf_a)
  );

  sha256_block_loader #(.DATA_W(8), .NBUF(NB_B)) dut_b (
    .clk(clk), .reset(reset), .data(d_b), .write_enable(we_b), .first_block(f_b),
    .last_block(l_b), .busy(busy_b), .blk_valid(vld_b), .blk_ready(rdy_b),
    .blk_data(bd_b), .blk_first(first_b), .blk_last(last_b), .level(lvl_b),
    .overflow_err(ovf_b)
  );

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int tests = 0;
  int fails = 0;

  // Reference model: message as a shift-in accumulator plus word count, FIFO as a block count.
  int           m_level [2];
  int           m_cnt   [2];
  logic [511:0] m_acc   [2];
  logic         m_first [2];
  logic         m_last  [2];
  logic         m_ovf   [2];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_level[i] = 0; m_cnt[i] = 0; m_acc[i] = '0;
      m_first[i] = 1'b0; m_last[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    exp_a.delete();
    exp_b.delete();
  endfunction

  // Effect of one clock edge given the inputs presented before it.
  function automatic void model_step(input int id, input logic we, input logic [127:0] d,
                                     input logic f, input logic l, input logic rdy);
    int   dw;
    int   nb;
    logic full;
    logic pop;
    exp_t e;
    dw   = (id == 0) ? 32 : 8;
    nb   = (id == 0) ? NB_A : NB_B;
    full = (m_level[id] == nb);
    pop  = (m_level[id] > 0) && rdy;
    if (we && full) m_ovf[id] = 1'b1;
    if (we && !full) begin
      if (f) begin
        m_cnt[id] = 0; m_acc[id] = '0; m_first[id] = 1'b1; m_last[id] = 1'b0;
      end
      m_acc[id] = (m_acc[id] << dw) | {384'd0, d};
      m_cnt[id] = m_cnt[id] + 1;
      m_last[id] = m_last[id] | l;
      if (m_cnt[id] == 512 / dw) begin
        e.d = m_acc[id]; e.f = m_first[id]; e.l = m_last[id];
        if (id == 0) exp_a.push_back(e); else exp_b.push_back(e);
        m_level[id] = m_level[id] + 1;
        m_cnt[id] = 0; m_acc[id] = '0; m_first[id] = 1'b0; m_last[id] = 1'b0;
      end
    end
    if (pop) m_level[id] = m_level[id] - 1;
  endfunction

  task automatic check_state(input string p, input int id, input int nb, input logic [2:0] lvl,
                             input logic bsy, input logic vld, input logic ovf,
                             input logic [511:0] bd, input logic bf, input logic bl);
    chk({p, ".level"}, 512'(lvl), 512'(m_level[id]));
    chk({p, ".busy"}, 512'(bsy), 512'(m_level[id] == nb));
    chk({p, ".blk_valid"}, 512'(vld), 512'(m_level[id] > 0));
    chk({p, ".overflow_err"}, 512'(ovf), 512'(m_ovf[id]));
    if (m_level[id] == 0) begin
      chk({p, ".idle_data"}, bd, 512'd0);
      chk({p, ".idle_flags"}, 512'({bf, bl}), 512'd0);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_a.outs", 512'({busy_a, vld_a, first_a, last_a, lvl_a, ovf_a}), 512'd0);
    chk("rst_a.blk_data", bd_a, 512'd0);
    chk("rst_b.outs", 512'({busy_b, vld_b, first_b, last_b, lvl_b, ovf_b}), 512'd0);
    chk("rst_b.blk_data", bd_b, 512'd0);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    model_step(0, we_a, {96'd0, d_a}, f_a, l_a, rdy_a);
    model_step(1, we_b, {120'd0, d_b}, f_b, l_b, rdy_b);
    @(posedge clk);
    #1;
    check_state("a", 0, NB_A, lvl_a, busy_a, vld_a, ovf_a, bd_a, first_a, last_a);
    check_state("b", 1, NB_B, lvl_b, busy_b, vld_b, ovf_b, bd_b, first_b, last_b);
    @(negedge clk);
  endtask

  task automatic wa(input logic [31:0] d, input logic f, input logic l, input logic rdy);
    we_a = 1'b1; d_a = d; f_a = f; l_a = l; rdy_a = rdy;
    tick();
    we_a = 1'b0; f_a = 1'b0; l_a = 1'b0;
  endtask

  task automatic wb(input logic [7:0] d, input logic f, input logic l, input logic rdy);
    we_b = 1'b1; d_b = d; f_b = f; l_b = l; rdy_b = rdy;
    tick();
    we_b = 1'b0; f_b = 1'b0; l_b = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    rdy_a = rdy; rdy_b = rdy;
    repeat (n) tick();
  endtask

  task automatic block_a(input logic rdy);
    for (int i = 0; i < 16; i++) wa($urandom, i == 0, i == 15, rdy);
  endtask

  // Monitors: compare the head block against the scoreboard on every handshake.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && vld_a && rdy_a) begin
        if (exp_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL blk_a.unexpected: got block %0h expected none", bd_a);
        end else begin
          e = exp_a.pop_front();
          chk("blk_a.data", bd_a, e.d);
          chk("blk_a.first", 512'(first_a), 512'(e.f));
          chk("blk_a.last", 512'(last_a), 512'(e.l));
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && vld_b && rdy_b) begin
        if (exp_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL blk_b.unexpected: got block %0h expected none", bd_b);
        end else begin
          e = exp_b.pop_front();
          chk("blk_b.data", bd_b, e.d);
          chk("blk_b.first", 512'(first_b), 512'(e.f));
          chk("blk_b.last", 512'(last_b), 512'(e.l));
        end
      end
    end
  end

  initial begin : stim
    logic [511:0] t1_exp;
    reset = 1'b0;
    we_a = 0; f_a = 0; l_a = 0; rdy_a = 0; d_a = '0;
    we_b = 0; f_b = 0; l_b = 0; rdy_b = 0; d_b = '0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single block, words 0..15, consumed immediately.
    t1_exp = '0;
    for (int i = 0; i < 16; i++) t1_exp = (t1_exp << 32) | 512'(i);
    for (int i = 0; i < 16; i++) wa(32'(i), i == 0, i == 15, 1'b1);
    chk("t1.valid_after_w15", 512'(vld_a), 512'd1);
    chk("t1.data", bd_a, t1_exp);
    chk("t1.flags", 512'({first_a, last_a}), 512'd3);
    idle(2, 1'b1);

    // Restart on word 5: the block is that word plus the 15 following.
    for (int i = 0; i < 5; i++) wa($urandom, i == 0, 1'b0, 1'b1);
    wa(32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) wa($urandom, 1'b0, i == 14, 1'b1);
    chk("t4.head_word", 512'(bd_a[511:480]), 512'(32'hA5A5A5A5));
    idle(2, 1'b1);

    // Commit and pop on the same edge at level 1.
    block_a(1'b0);
    for (int i = 0; i < 15; i++) wa($urandom, i == 0, 1'b0, 1'b0);
    wa($urandom, 1'b0, 1'b1, 1'b1);
    chk("t3.level_held", 512'(lvl_a), 512'd1);
    idle(3, 1'b1);

    // Fill both slots, drop a third block, then drain.
    block_a(1'b0);
    block_a(1'b0);
    chk("t2.busy_full", 512'(busy_a), 512'd1);
    block_a(1'b0);
    chk("t2.overflow", 512'(ovf_a), 512'd1);
    idle(4, 1'b1);

    // Random traffic on both instances.
    for (int c = 0; c < 800; c++) begin
      we_a = ($urandom_range(0, 9) < 7); d_a = $urandom;
      f_a = ($urandom_range(0, 19) == 0); l_a = ($urandom_range(0, 9) == 0);
      rdy_a = $urandom_range(0, 1);
      we_b = ($urandom_range(0, 9) < 8); d_b = 8'($urandom);
      f_b = ($urandom_range(0, 149) == 0); l_b = ($urandom_range(0, 29) == 0);
      rdy_b = ($urandom_range(0, 3) == 0);
      tick();
    end
    we_a = 0; f_a = 0; l_a = 0; we_b = 0; f_b = 0; l_b = 0;
    idle(6, 1'b1);

    // Asynchronous reset mid-block with one block stored.
    block_a(1'b0);
    for (int i = 0; i < 7; i++) wa($urandom, i == 0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    block_a(1'b1);
    idle(3, 1'b1);

    // Byte-wide instance: 64 bytes 0x61..0xA0.
    for (int i = 0; i < 64; i++) wb(8'(8'h61 + i), i == 0, i == 63, 1'b1);
    chk("t6.first_byte", 512'(bd_b[511:504]), 512'(8'h61));
    chk("t6.last_byte", 512'(bd_b[7:0]), 512'(8'hA0));
    idle(3, 1'b1);

    idle(10, 1'b1);
    chk("drain_a.empty", 512'(exp_a.size()), 512'd0);
    chk("drain_b.empty", 512'(exp_b.size()), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
